jk_ff_checker: RTL and testbench
================================

JK_FF_CHECKER -- requirements
Module: jk_ff_checker

Interface
REQ-001 Parameter CNT_W, default 16, width of the check and error counters.
REQ-002 Parameter HALT_ON_ERROR, default 0; when 1, the first mismatch stops checking.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 enable  input  1  sample-qualify; the checker acts only on edges where enable=1.
REQ-006 j  input  1  J input driven to the flip-flop under test, stable before the edge.
REQ-007 k  input  1  K input driven to the flip-flop under test, stable before the edge.
REQ-008 q  input  1  Q output of the flip-flop under test, sampled pre-edge.
REQ-009 q_bar  input  1  Q_bar output of the flip-flop under test, sampled pre-edge.
REQ-010 expected_q  output  1  reference-model prediction of q for the next sampled edge.
REQ-011 mismatch  output  1  one-cycle pulse; the last sampled edge failed a check.
REQ-012 error_sticky  output  1  set on the first mismatch; cleared only by reset.
REQ-013 check_count  output  CNT_W  number of edges checked in CHECK.
REQ-014 error_count  output  CNT_W  number of mismatching edges.
REQ-015 state  output  2  FSM state: 00 IDLE, 01 SYNC, 10 CHECK, 11 HALT.

Function
REQ-016 FSM transitions: IDLE->SYNC on enable=1; SYNC->CHECK on the next enabled edge; CHECK->HALT on a mismatch when HALT_ON_ERROR=1; HALT holds until reset.
REQ-017 On the IDLE->SYNC edge, q is unknown and the checker SHALL perform no comparison and load nothing.
REQ-018 On the enabled SYNC edge, the checker SHALL load expected_q <= jk(q,j,k) with no comparison.
REQ-019 jk(s,j,k) is defined as follows: 00->s, 01->0, 10->1, 11->~s.
REQ-020 On each enabled CHECK edge, the checker SHALL compare q against expected_q and q_bar against ~q, then update expected_q <= jk(expected_q,j,k).
REQ-021 The model SHALL advance from expected_q, not from q, so a single DUT fault is not masked on later edges.
REQ-022 Each enabled CHECK edge SHALL increment check_count by 1, saturating at all-ones.
REQ-023 A failure of either comparison SHALL set mismatch=1 for exactly the next cycle, increment error_count (saturating), and set error_sticky.
REQ-024 A double failure on one edge SHALL count as one error.
REQ-025 Edges with enable=0 SHALL leave all state, counters and expected_q unchanged and hold mismatch=0.
REQ-026 Latency: mismatch and the counter updates SHALL be visible one cycle after the failing sampling edge.
REQ-027 In HALT, counters and expected_q SHALL be frozen and mismatch held at 0.
REQ-028 Saturated counters SHALL hold all-ones without wrapping; error_sticky remains the definitive flag.

Reset
REQ-029 While reset=1 at an edge: state=IDLE, expected_q=0, mismatch=0, error_sticky=0, check_count=0, error_count=0.
REQ-030 Reset SHALL take priority over enable and apply from any state, including mid-CHECK and HALT.
REQ-031 After reset, the checker SHALL resynchronise via IDLE->SYNC before any comparison.

Verification
REQ-032 Reset, enable=1, then drive j/k = 10,00,01,11,11 against a correct DUT with q_bar=~q -> mismatch never 1, error_count=0, check_count=4 after the last edge.
REQ-033 Correct DUT in CHECK with q forced to 0 on one edge where expected_q=1 -> mismatch pulses once, error_count=1, error_sticky=1, and later edges with the correct DUT produce no further errors.
REQ-034 Correct DUT in CHECK with q_bar=q=1 on one edge -> error_count=1; with both the q and q_bar checks failing on one edge -> error_count increments by 1 only.
REQ-035 HALT_ON_ERROR=1 with one injected fault -> state=11 next cycle and counters frozen across 10 further edges; assert reset -> state=00 and all outputs 0.
REQ-036 CNT_W=4 with 20 enabled CHECK edges and a persistently wrong q -> check_count=15, error_count=15, no wrap.
REQ-037 enable toggling 1,0,0,1 in CHECK -> check_count advances by 2 only, and expected_q is unchanged across the disabled edges.

Source files
------------

// File: rtl/jk_ff_checker.sv
// Reference-model checker for a JK flip-flop under test.
// Tracks the predicted Q and counts checked and failing edges.
module jk_ff_checker #(
   parameter int CNT_W         = 16,
   parameter bit HALT_ON_ERROR = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             j,
   input  logic             k,
   input  logic             q,
   input  logic             q_bar,
   output logic             expected_q,
   output logic             mismatch,
   output logic             error_sticky,
   output logic [CNT_W-1:0] check_count,
   output logic [CNT_W-1:0] error_count,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SYNC  = 2'b01,
      CHECK = 2'b10,
      HALT  = 2'b11
   } state_e;

   state_e           state_q;
   logic             exp_q;
   logic             mis_q;
   logic             sticky_q;
   logic [CNT_W-1:0] chk_q;
   logic [CNT_W-1:0] err_q;

   logic             fail_d;
   logic             sync_d;
   logic             adv_d;
   logic [CNT_W-1:0] chk_d;
   logic [CNT_W-1:0] err_d;

   function automatic logic jk_f(input logic s, input logic jj, input logic kk);
      logic r;
      case ({jj, kk})
         2'b00:   r = s;
         2'b01:   r = 1'b0;
         2'b10:   r = 1'b1;
         default: r = ~s;
      endcase
      return r;
   endfunction

   always_comb begin
      fail_d = (q != exp_q) || (q_bar != ~q);
      sync_d = jk_f(q, j, k);
      // the model advances from its own prediction so one bad edge is not masked
      adv_d  = jk_f(exp_q, j, k);
      chk_d  = (chk_q == '1) ? chk_q : chk_q + 1'b1;
      err_d  = (err_q == '1) ? err_q : err_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         exp_q    <= 1'b0;
         mis_q    <= 1'b0;
         sticky_q <= 1'b0;
         chk_q    <= '0;
         err_q    <= '0;
      end else begin
         mis_q <= 1'b0;
         if (enable) begin
            unique case (state_q)
               IDLE: state_q <= SYNC;
               SYNC: begin
                  exp_q   <= sync_d;
                  state_q <= CHECK;
               end
               CHECK: begin
                  chk_q <= chk_d;
                  exp_q <= adv_d;
                  if (fail_d) begin
                     mis_q    <= 1'b1;
                     err_q    <= err_d;
                     sticky_q <= 1'b1;
                     if (HALT_ON_ERROR) state_q <= HALT;
                  end
               end
               HALT: state_q <= HALT;
            endcase
         end
      end
   end

   assign expected_q   = exp_q;
   assign mismatch     = mis_q;
   assign error_sticky = sticky_q;
   assign check_count  = chk_q;
   assign error_count  = err_q;
   assign state        = state_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed bench for jk_ff_checker: default, halting and
// narrow-counter instances share one stimulus stream.
module tb_jk_ff_checker;

   logic clock = 1'b0;
   logic reset, enable, j, k, q, q_bar;

   logic        e0, m0, s0;
   logic [15:0] c0, r0;
   logic [1:0]  t0;
   logic        e1, m1, s1;
   logic [15:0] c1, r1;
   logic [1:0]  t1;
   logic        e2, m2, s2;
   logic [3:0]  c2, r2;
   logic [1:0]  t2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   jk_ff_checker u0 (
      .clock(clock), .reset(reset), .enable(enable), .j(j), .k(k),
      .q(q), .q_bar(q_bar), .expected_q(e0), .mismatch(m0),
      .error_sticky(s0), .check_count(c0), .error_count(r0), .state(t0)
   );

   jk_ff_checker #(.HALT_ON_ERROR(1'b1)) u1 (
      .clock(clock), .reset(reset), .enable(enable), .j(j), .k(k),
      .q(q), .q_bar(q_bar), .expected_q(e1), .mismatch(m1),
      .error_sticky(s1), .check_count(c1), .error_count(r1), .state(t1)
   );

   jk_ff_checker #(.CNT_W(4)) u2 (
      .clock(clock), .reset(reset), .enable(enable), .j(j), .k(k),
      .q(q), .q_bar(q_bar), .expected_q(e2), .mismatch(m2),
      .error_sticky(s2), .check_count(c2), .error_count(r2), .state(t2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rs, input logic en, input logic jj,
                       input logic kk, input logic qq, input logic qb);
      reset  = rs;
      enable = en;
      j      = jj;
      k      = kk;
      q      = qq;
      q_bar  = qb;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; j = 1'b0;
      k = 1'b0; q = 1'b0; q_bar = 1'b1;

      // reset state
      step(1, 0, 0, 0, 0, 1);
      chk("rst_state", t0, 0);
      chk("rst_expq", e0, 0);
      chk("rst_mis", m0, 0);
      chk("rst_sticky", s0, 0);
      chk("rst_cc", c0, 0);
      chk("rst_ec", r0, 0);
      chk("rst_state_h", t1, 0);
      chk("rst_cc_n", c2, 0);

      // clean run: idle, sync on jk=10, then 00,01,11,11
      step(0, 1, 0, 0, 0, 1);
      chk("idle_sync", t0, 1);
      chk("idle_noload", e0, 0);
      step(0, 1, 1, 0, 0, 1);
      chk("sync_state", t0, 2);
      chk("sync_load", e0, 1);
      step(0, 1, 0, 0, 1, 0);
      chk("ok1_mis", m0, 0);
      step(0, 1, 0, 1, 1, 0);
      chk("ok2_mis", m0, 0);
      step(0, 1, 1, 1, 0, 1);
      chk("ok3_mis", m0, 0);
      step(0, 1, 1, 1, 1, 0);
      chk("ok4_mis", m0, 0);
      chk("clean_cc", c0, 4);
      chk("clean_ec", r0, 0);
      chk("clean_expq", e0, 0);

      // q forced low where expected_q=1
      step(0, 1, 1, 0, 0, 1);
      chk("pre_fault_expq", e0, 1);
      step(0, 1, 0, 0, 0, 1);
      chk("qfault_mis", m0, 1);
      chk("qfault_ec", r0, 1);
      chk("qfault_sticky", s0, 1);
      chk("qfault_cc", c0, 6);
      chk("halt_state", t1, 3);
      step(0, 1, 0, 0, 1, 0);
      chk("post_mis", m0, 0);
      chk("post_ec", r0, 1);
      chk("post_sticky", s0, 1);
      chk("post_cc", c0, 7);

      // q_bar only, then q and q_bar both wrong
      step(0, 1, 0, 1, 1, 1);
      chk("qbfault_mis", m0, 1);
      chk("qbfault_ec", r0, 2);
      chk("qbfault_expq", e0, 0);
      step(0, 1, 0, 0, 1, 1);
      chk("dbl_mis", m0, 1);
      chk("dbl_ec", r0, 3);
      step(0, 1, 0, 0, 0, 1);
      chk("dbl_after_mis", m0, 0);
      chk("dbl_after_ec", r0, 3);
      chk("dbl_after_cc", c0, 10);

      // enable 1,0,0,1 with garbage on the disabled edges
      step(0, 1, 1, 0, 0, 1);
      chk("en1_expq", e0, 1);
      chk("en1_cc", c0, 11);
      step(0, 0, 0, 1, 0, 1);
      chk("en0a_expq", e0, 1);
      chk("en0a_cc", c0, 11);
      chk("en0a_mis", m0, 0);
      step(0, 0, 1, 1, 0, 0);
      chk("en0b_expq", e0, 1);
      chk("en0b_cc", c0, 11);
      chk("en0b_mis", m0, 0);
      chk("en0b_state", t0, 2);
      step(0, 1, 0, 0, 1, 0);
      chk("en1b_cc", c0, 12);
      chk("en1b_expq", e0, 1);
      chk("en1b_ec", r0, 3);
      chk("en1b_mis", m0, 0);

      // reset mid-CHECK wins over enable
      step(1, 1, 1, 0, 0, 0);
      chk("midrst_state", t0, 0);
      chk("midrst_expq", e0, 0);
      chk("midrst_cc", c0, 0);
      chk("midrst_ec", r0, 0);
      chk("midrst_sticky", s0, 0);
      chk("midrst_state_h", t1, 0);
      step(0, 1, 0, 0, 0, 1);
      chk("resync_state", t0, 1);
      chk("resync_ec", r0, 0);

      // halting instance: one fault, then ten frozen edges
      step(0, 1, 0, 0, 0, 1);
      chk("h_sync", t1, 2);
      step(0, 1, 1, 0, 0, 1);
      chk("h_ok_cc", c1, 1);
      step(0, 1, 0, 0, 0, 1);
      chk("h_state", t1, 3);
      chk("h_mis", m1, 1);
      chk("h_ec", r1, 1);
      chk("h_cc", c1, 2);
      chk("h_expq", e1, 1);
      for (int i = 0; i < 10; i++) step(0, 1, i[0], i[1], 0, 0);
      chk("hf_state", t1, 3);
      chk("hf_cc", c1, 2);
      chk("hf_ec", r1, 1);
      chk("hf_mis", m1, 0);
      chk("hf_expq", e1, 1);
      chk("hf_sticky", s1, 1);
      step(1, 1, 0, 0, 0, 0);
      chk("hr_state", t1, 0);
      chk("hr_expq", e1, 0);
      chk("hr_mis", m1, 0);
      chk("hr_sticky", s1, 0);
      chk("hr_cc", c1, 0);
      chk("hr_ec", r1, 0);

      // 4-bit counters saturate under a persistently wrong q
      step(0, 1, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 1);
      chk("n_sync_expq", e2, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, 0);
      chk("n_cc_sat", c2, 15);
      chk("n_ec_sat", r2, 15);
      chk("n_sticky", s2, 1);
      chk("n_state", t2, 2);
      chk("n_mis", m2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
